// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. One full-adder cell is applied
//               LSB-first over WIDTH-bit operands under a start/busy/done
//               handshake. Define SERIAL_ADD_SUB_EN to add the `sub` port
//               (two's-complement subtraction).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   b_load;
    logic               c_load;
    logic               fa_sum;
    logic               fa_carry;

    // Subtraction is A + ~B + 1, so only the loaded B and carry-in differ.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load = sub ? ~op_b : op_b;
    assign c_load = sub ? 1'b1  : cin;
`else
    assign b_load = op_b;
    assign c_load = cin;
`endif

    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = b_load;
                    carry_d  = c_load;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                carry_d  = fa_carry;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    cout_d  = fa_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (vector table,
//               scoreboard queue, handshake corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] r;
        logic         co;
    } vec_t;

    typedef struct {
        logic [W-1:0] r;
        logic         co;
    } exp_t;

    exp_t   sb[$];
    longint done_times[$];
    int     checks = 0;
    int     fails  = 0;
    int     dones_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] r, input logic co);
        exp_t e;
        e.r  = r;
        e.co = co;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done) begin
                dones_seen++;
                done_times.push_back($time);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", {24'd0, result}, {24'd0, e.r});
                    chk("cout", {31'd0, cout}, {31'd0, e.co});
                end
            end
        end
    end

    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int k = 1; k <= W + 8; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                return;
            end
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    // One operation from IDLE; operands are scrambled right after capture.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] r, input logic co);
        int lat, nb;
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        push(r, co);
        #1;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
        wait_done(lat, nb);
        chk("latency", lat, W + 1);
        chk("busy_cycles", nb, W);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [6];

    initial begin
        int lat, nb;
        logic [W:0] ref_sum;
        logic [W-1:0] ra, rb;
        logic rc;

        tbl[0] = '{a: 8'h5A, b: 8'h3C, c: 1'b0, r: 8'h96, co: 1'b0};
        tbl[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, r: 8'h00, co: 1'b1};
        tbl[2] = '{a: 8'h00, b: 8'h00, c: 1'b1, r: 8'h01, co: 1'b0};
        tbl[3] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, r: 8'hFF, co: 1'b1};
        tbl[4] = '{a: 8'h80, b: 8'h80, c: 1'b0, r: 8'h00, co: 1'b1};
        tbl[5] = '{a: 8'h12, b: 8'h34, c: 1'b0, r: 8'h46, co: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].co);

        // start pulsed mid-RUN with different operands must be ignored
        op_a = 8'h5A; op_b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        push(8'h96, 1'b0);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 op_a = 8'h11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, nb);
        chk("ignore_latency", lat, W - 2);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", {24'd0, result}, 32'h96);
            chk("hold_cout", {31'd0, cout}, 32'd0);
        end
        chk("ignored_start_no_extra", sb.size(), 0);

        // start held high: back-to-back every W+2 cycles
        @(posedge clk);
        #1;
        done_times.delete();
        op_a = 8'h01; op_b = 8'h02; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        push(8'h03, 1'b0);
        #1 op_a = 8'h10; op_b = 8'h20; cin = 1'b1;
        repeat (W + 2) @(posedge clk);
        push(8'h31, 1'b0);
        #1 op_a = 8'hF0; op_b = 8'h20; cin = 1'b0;
        repeat (W + 2) @(posedge clk);
        push(8'h10, 1'b1);
        #1 start = 1'b0;
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        chk("b2b_drained", sb.size(), 0);
        chk("b2b_count", done_times.size(), 3);
        if (done_times.size() == 3) begin
            chk("b2b_spacing1", 32'(done_times[1] - done_times[0]), 32'(10 * (W + 2)));
            chk("b2b_spacing2", 32'(done_times[2] - done_times[1]), 32'(10 * (W + 2)));
        end
        @(posedge clk);
        #1;

        // reset sampled at E4 aborts the operation
        op_a = 8'hFF; op_b = 8'h01; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dones_seen = 0;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", dones_seen, 0);
        @(posedge clk);
        #1;
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        do_op(8'h50, 8'h20, 1'b0, 8'h30, 1'b1);
        do_op(8'h20, 8'h50, 1'b0, 8'hD0, 1'b0);
        sub = 1'b0;
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sub = 1'($urandom);
            if (sub)
                ref_sum = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
            else
                ref_sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
`else
            ref_sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
`endif
            do_op(ra, rb, rc, ref_sum[W-1:0], ref_sum[W]);
        end

        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", checks - fails, checks);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller.
- Sequences one 1-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)) over WIDTH-bit operands, LSB first, one bit per clock.
- Provides a start/busy/done handshake so upstream logic can request multi-bit additions from a single shared full-adder resource.
- Sits between operand-producing logic and the full-adder cell; owns operand shift registers, the carry flop and the result register.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  operand A, captured on accepted start
- op_b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  sum; valid from done, held until next accepted start
- cout  output  1  final carry-out; valid and held like result

Behaviour:
- One clock (clk) and one reset (rst_n): synchronous, active-low. rst_n low at any rising edge forces state IDLE and busy=0, done=0, result=0, cout=0, bit counter=0, carry flop=0.
- Reset mid-operation aborts the operation. Captured operands are discarded and no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge E0: capture op_a, op_b into shift registers; load carry flop with cin; clear counter; clear result; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - At each edge, feed the LSBs of the A and B shift registers plus the carry flop into the full-adder cell.
  - Shift the cell's sum into result at the MSB (shift right), update the carry flop with the cell's carry, shift both operand registers right and increment the counter.
  - After edge E_WIDTH (counter reaches WIDTH-1 and is processed), go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE at the next edge.
- Outputs per state:
  - busy=1 exactly in RUN (WIDTH cycles).
  - done=1 exactly in DONE (the cycle after edge E_WIDTH).
  - cout = carry flop value, exposed from DONE onward.
- Latency: start sampled at E0 → done high during cycle following E_WIDTH. Next start can be accepted at E_(WIDTH+2) at the earliest, so one operation every WIDTH+2 cycles.
- start in RUN or DONE is ignored and is not queued. Operand changes after E0 have no effect.
- start held high continuously: back-to-back operations, each re-capturing operands when IDLE is reached.
- Arithmetic is modulo 2^WIDTH; overflow is reported only via cout.
- result and cout hold their values in IDLE until the next accepted start. On an accepted start, result is cleared and cout reads 0 until DONE.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds port `sub` (input, 1), captured with operands at accepted start.
  - sub=1: B shift register is loaded with ~op_b, carry flop is loaded with 1 (cin ignored), and result = op_a − op_b modulo 2^WIDTH. cout=1 means no borrow (op_a ≥ op_b unsigned).
  - sub=0: plain addition, identical to the undefined case.
- Undefined: no `sub` port; block always adds with cin.

Test Plan:
- Reset, then WIDTH=8, op_a=0x5A, op_b=0x3C, cin=0, start at E0 → busy high 8 cycles, done pulse after E8, result=0x96, cout=0; result held through 5 idle cycles.
- op_a=0xFF, op_b=0x01, cin=0 → result=0x00, cout=1; then op_a=0x00, op_b=0x00, cin=1 → result=0x01, cout=0.
- start pulsed again during RUN with op_a=0x11 → ignored; first result unaffected. Start held high continuously → done every 10 cycles, operands re-captured each time.
- rst_n low at E4 of an operation → next cycle busy=0, done=0, result=0, cout=0; no done pulse; a fresh start afterwards completes correctly (0x12+0x34=0x46).
- SERIAL_ADD_SUB_EN defined, sub=1: op_a=0x50, op_b=0x20 → result=0x30, cout=1; op_a=0x20, op_b=0x50 → result=0xD0, cout=0.
- Randomised 1000 operations vs. reference sum (op_a+op_b+cin) → result and cout match at every done pulse; busy and done never high together.
